// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//   Shared definitions for the mesh router input stage.
//   - Direction indices used for the one-hot out_req / out_grant vectors.
//   - Packet field offsets: [31:16] router address, [15:0] neuron address.
//   - Input-port FSM state encoding.
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int NUM_DIRS   = 5;
  localparam int DIR_LOCAL  = 0;
  localparam int DIR_NORTH  = 1;
  localparam int DIR_EAST   = 2;
  localparam int DIR_SOUTH  = 3;
  localparam int DIR_WEST   = 4;

  localparam int PACKET_WIDTH    = 32;
  localparam int ROUTER_ADDR_LSB = 16;
  localparam int NEURON_ADDR_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROUTE   = 2'd1,
    ST_REQUEST = 2'd2
  } port_state_e;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO, depth 2**ADDR_WIDTH, show-ahead read (rd_data always
//   shows the oldest entry; pop advances to the next one).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data   write request and data; ignored while full
//   pop             read request; ignored while empty
//   rd_data         oldest entry (valid only while !empty)
//   full, empty     occupancy flags
//   count           current occupancy, 0..2**ADDR_WIDTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One extra pointer bit: equal low bits with differing MSBs means the
  // write pointer has lapped the read pointer (full), identical means empty.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/router_input_port.sv
// -----------------------------------------------------------------------------
// router_input_port
//   One input direction of the mesh router. Buffers incoming packets in a
//   FIFO, routes the head packet X-then-Y against this router's coordinates
//   and holds a one-hot request to the switch allocator until granted.
// Ports:
//   net_clk, net_rst_n   clock, asynchronous active-low reset
//   local_x, local_y     this router's coordinates (static after reset)
//   in_packet, in_valid, in_ready
//                        upstream handshake
//   out_packet, out_req  head packet and one-hot direction request
//                        (bit0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST)
//   out_grant            allocator grant, one-hot or zero
//   pkt_count            packets forwarded since reset (wraps)
//   grant_err            sticky: a grant arrived that missed out_req
//   dbg_state            current FSM state (port_state_e encoding)
//
// Handshakes: upstream transfer happens on a rising edge where
//   in_valid && in_ready; in_packet must be stable while in_valid is high.
//   Downstream transfer happens on a rising edge where out_req is nonzero
//   and |(out_grant & out_req); out_req/out_packet hold until then.
// -----------------------------------------------------------------------------
module router_input_port
  import noc_pkg::*;
#(
  parameter int X_WIDTH        = 2,
  parameter int Y_WIDTH        = 2,
  parameter int BUF_ADDR_WIDTH = 2
) (
  input  logic                    net_clk,
  input  logic                    net_rst_n,
  input  logic [X_WIDTH-1:0]      local_x,
  input  logic [Y_WIDTH-1:0]      local_y,
  input  logic [PACKET_WIDTH-1:0] in_packet,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [PACKET_WIDTH-1:0] out_packet,
  output logic [NUM_DIRS-1:0]     out_req,
  input  logic [NUM_DIRS-1:0]     out_grant,
  output logic [15:0]             pkt_count,
  output logic                    grant_err,
  output logic [1:0]              dbg_state
);

  localparam logic [BUF_ADDR_WIDTH:0] FULL_COUNT = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};

  port_state_e               state;
  logic [PACKET_WIDTH-1:0]   head_reg;
  logic [NUM_DIRS-1:0]       route_reg;
  logic [NUM_DIRS-1:0]       route_next;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [PACKET_WIDTH-1:0]   fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [BUF_ADDR_WIDTH:0]   fifo_count;
  logic [BUF_ADDR_WIDTH:0]   next_count;
  logic                      grant_hit;

  logic [X_WIDTH-1:0]        dest_x;
  logic [Y_WIDTH-1:0]        dest_y;

  // ---------------------------------------------------------------------------
  // Buffer
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .DATA_WIDTH (PACKET_WIDTH),
    .ADDR_WIDTH (BUF_ADDR_WIDTH)
  ) u_fifo (
    .clk     (net_clk),
    .rst_n   (net_rst_n),
    .push    (fifo_push),
    .wr_data (in_packet),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fifo_push = in_valid && in_ready;
  assign grant_hit = (state == ST_REQUEST) && |(out_grant & route_reg);

  // Pop when idle with data waiting, or when the current head leaves and
  // another packet is queued behind it.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || grant_hit);

  // Occupancy after this edge; in_ready is registered from it so that a
  // push which fills the FIFO drops in_ready on the very same edge. A pop
  // never frees space for a push in the same cycle (no bypass).
  assign next_count = fifo_count
                    + {{BUF_ADDR_WIDTH{1'b0}}, fifo_push}
                    - {{BUF_ADDR_WIDTH{1'b0}}, fifo_pop};

  // ---------------------------------------------------------------------------
  // Dimension-ordered route of the head packet: resolve X first, then Y.
  // Router-address bits above the X/Y fields are ignored.
  // ---------------------------------------------------------------------------
  assign dest_x = head_reg[ROUTER_ADDR_LSB +: X_WIDTH];
  assign dest_y = head_reg[ROUTER_ADDR_LSB + X_WIDTH +: Y_WIDTH];

  always_comb begin
    route_next = '0;
    if (dest_x > local_x) begin
      route_next[DIR_EAST] = 1'b1;
    end else if (dest_x < local_x) begin
      route_next[DIR_WEST] = 1'b1;
    end else if (dest_y > local_y) begin
      route_next[DIR_NORTH] = 1'b1;
    end else if (dest_y < local_y) begin
      route_next[DIR_SOUTH] = 1'b1;
    end else begin
      route_next[DIR_LOCAL] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. route_reg is only nonzero in REQUEST, so it drives out_req
  // directly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge net_clk or negedge net_rst_n) begin
    if (!net_rst_n) begin
      state      <= ST_IDLE;
      head_reg   <= '0;
      route_reg  <= '0;
      out_packet <= '0;
      pkt_count  <= '0;
      grant_err  <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      in_ready <= (next_count != FULL_COUNT);

      case (state)
        ST_IDLE: begin
          route_reg <= '0;
          if (!fifo_empty) begin
            head_reg <= fifo_rd_data;
            state    <= ST_ROUTE;
          end
        end

        ST_ROUTE: begin
          route_reg  <= route_next;
          out_packet <= head_reg;
          state      <= ST_REQUEST;
        end

        ST_REQUEST: begin
          if (grant_hit) begin
            pkt_count <= pkt_count + 16'd1;
            route_reg <= '0;
            if (!fifo_empty) begin
              head_reg <= fifo_rd_data;
              state    <= ST_ROUTE;
            end else begin
              state    <= ST_IDLE;
            end
          end else if (|out_grant) begin
            // Grant aimed at another direction: flag it, keep requesting.
            grant_err <= 1'b1;
          end
        end

        default: begin
          route_reg <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_req   = route_reg;
  assign dbg_state = state;

endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;
  import noc_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        net_clk = 1'b0;
  logic        net_rst_n;
  logic [1:0]  local_x;
  logic [1:0]  local_y;
  logic [31:0] in_packet;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_packet;
  logic [4:0]  out_req;
  logic [4:0]  out_grant;
  logic [15:0] pkt_count;
  logic        grant_err;
  logic [1:0]  dbg_state;

  always #5 net_clk = ~net_clk;

  router_input_port #(
    .X_WIDTH        (2),
    .Y_WIDTH        (2),
    .BUF_ADDR_WIDTH (2)
  ) dut (
    .net_clk    (net_clk),
    .net_rst_n  (net_rst_n),
    .local_x    (local_x),
    .local_y    (local_y),
    .in_packet  (in_packet),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_packet (out_packet),
    .out_req    (out_req),
    .out_grant  (out_grant),
    .pkt_count  (pkt_count),
    .grant_err  (grant_err),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  logic [1:0]  rx [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
  logic [1:0]  ry [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
  logic [4:0]  rq [4] = '{5'b10000, 5'b00010, 5'b01000, 5'b00001};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_pkt(input logic [1:0] x, input logic [1:0] y,
                                         input logic [15:0] nrn);
    return {12'hA5C, y, x, nrn};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change and outputs are sampled 1 ns after posedge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge net_clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] p);
    check("push_ready", 32'(in_ready), 32'd1);
    in_packet = p;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_req(input logic [4:0] exp_req);
    for (int k = 0; k < 20 && out_req == 5'd0; k++) step();
    check("wait_req", 32'(out_req), 32'(exp_req));
  endtask

  task automatic grant_now(input logic [4:0] g);
    out_grant = g;
    step();
    out_grant = 5'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] p;
    logic [31:0] got;
    logic [31:0] want;
    int          accepted;
    int          last_t;
    int          xfers;

    local_x   = 2'd1;
    local_y   = 2'd1;
    in_valid  = 1'b0;
    in_packet = '0;
    out_grant = '0;
    net_rst_n = 1'b0;
    step();
    step();

    // Reset state
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_out_req",    32'(out_req),    32'd0);
    check("rst_out_packet", out_packet,      32'd0);
    check("rst_pkt_count",  32'(pkt_count),  32'd0);
    check("rst_grant_err",  32'(grant_err),  32'd0);
    check("rst_state",      32'(dbg_state),  32'(ST_IDLE));

    net_rst_n = 1'b1;
    check("rel_in_ready_0", 32'(in_ready), 32'd0);
    step();
    check("rel_in_ready_1", 32'(in_ready), 32'd1);

    // Latency: push at edge N, head at N+1, request after N+2
    p = mk_pkt(2'd2, 2'd1, 16'h0001);
    push1(p);
    check("lat_n_req",    32'(out_req),   32'd0);
    check("lat_n_state",  32'(dbg_state), 32'(ST_IDLE));
    step();
    check("lat_n1_req",   32'(out_req),   32'd0);
    check("lat_n1_state", 32'(dbg_state), 32'(ST_ROUTE));
    step();
    check("lat_n2_req",   32'(out_req),   32'b00100);
    check("lat_n2_pkt",   out_packet,     p);
    check("lat_n2_state", 32'(dbg_state), 32'(ST_REQUEST));
    grant_now(5'b00100);
    check("east_count",   32'(pkt_count), 32'd1);
    check("east_req_off", 32'(out_req),   32'd0);
    check("east_pkt_hold", out_packet,    p);

    // Remaining directions: WEST, NORTH, SOUTH, LOCAL
    for (int i = 0; i < 4; i++) begin
      p = mk_pkt(rx[i], ry[i], 16'h0010 + 16'(i));
      push1(p);
      wait_req(rq[i]);
      check("route_pkt", out_packet, p);
      grant_now(rq[i]);
      check("route_count", 32'(pkt_count), 32'(i + 2));
    end

    // Grant in IDLE is ignored
    out_grant = 5'b11111;
    step();
    step();
    out_grant = 5'd0;
    check("idle_grant_err",   32'(grant_err), 32'd0);
    check("idle_grant_count", 32'(pkt_count), 32'd5);

    // Mismatched grant: sticky error, no transfer
    p = mk_pkt(2'd2, 2'd1, 16'h0100);
    push1(p);
    wait_req(5'b00100);
    grant_now(5'b00010);
    check("bad_grant_err",   32'(grant_err), 32'd1);
    check("bad_grant_count", 32'(pkt_count), 32'd5);
    check("bad_grant_req",   32'(out_req),   32'b00100);
    step();
    check("bad_grant_sticky", 32'(grant_err), 32'd1);
    grant_now(5'b00100);
    check("good_grant_count", 32'(pkt_count), 32'd6);
    check("good_grant_err",   32'(grant_err), 32'd1);

    // Fill: one head in REQUEST, then exactly 4 more accepted
    p = mk_pkt(2'd1, 2'd1, 16'h0200);
    push1(p);
    exp_q.push_back(p);
    wait_req(5'b00001);
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      p = {16'h0003, 16'h0300 + 16'(i)};
      in_packet = p;
      in_valid  = 1'b1;
      if (in_ready) begin
        accepted++;
        exp_q.push_back(p);
      end
      step();
    end
    in_valid = 1'b0;
    check("fill_accepted", 32'(accepted), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);

    // Drain with continuous grant: order preserved, one every 2 cycles
    out_grant = 5'b11111;
    last_t = -1;
    xfers  = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_req != 5'd0) begin
        got  = out_packet;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check("drain_data", got, want);
        if (xfers > 0) check("drain_gap", 32'(c - last_t), 32'd2);
        last_t = c;
        xfers++;
      end
      step();
    end
    out_grant = 5'd0;
    check("drain_xfers", 32'(xfers), 32'd5);
    check("drain_count", 32'(pkt_count), 32'd11);
    check("drain_ready", 32'(in_ready), 32'd1);

    // Counter wrap
    force dut.pkt_count = 16'hFFFF;
    #1;
    release dut.pkt_count;
    check("wrap_preload", 32'(pkt_count), 32'h0000FFFF);
    p = mk_pkt(2'd0, 2'd0, 16'h0400);
    push1(p);
    wait_req(5'b10000);
    grant_now(5'b10000);
    check("wrap_count", 32'(pkt_count), 32'd0);

    // Random push/pop to wrap FIFO pointers
    exp_q.delete();
    xfers = 0;
    for (int c = 0; c < 70; c++) begin
      if (c < 40) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_packet = $urandom();
        out_grant = ($urandom_range(0, 1) != 0) ? 5'b11111 : 5'd0;
      end else begin
        in_valid  = 1'b0;
        out_grant = 5'b11111;
      end
      if (in_valid && in_ready) exp_q.push_back(in_packet);
      if (out_req != 5'd0 && out_grant != 5'd0) begin
        got  = out_packet;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check("rand_data", got, want);
        xfers++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_grant = 5'd0;
    check("rand_left",  32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(pkt_count),    32'(xfers));

    // Reset mid-operation: head in REQUEST, 3 buffered
    for (int i = 0; i < 4; i++) push1(mk_pkt(2'd1, 2'd1, 16'h0500 + 16'(i)));
    wait_req(5'b00001);
    net_rst_n = 1'b0;
    #1;
    check("mrst_out_req",  32'(out_req),   32'd0);
    check("mrst_in_ready", 32'(in_ready),  32'd0);
    check("mrst_state",    32'(dbg_state), 32'(ST_IDLE));
    check("mrst_pkt",      out_packet,     32'd0);
    step();
    net_rst_n = 1'b1;
    step();
    check("mrst_rel_ready", 32'(in_ready),  32'd1);
    check("mrst_rel_count", 32'(pkt_count), 32'd0);
    check("mrst_rel_err",   32'(grant_err), 32'd0);
    step();
    step();
    step();
    check("mrst_empty_req",   32'(out_req),   32'd0);
    check("mrst_empty_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
